// File: rtl/pcs_tx_frame_gen.sv
// pcs_tx_frame_gen: synthetic Ethernet frame source for the pcs_tx MAC-side bus.
// Emits start word, incrementing-pattern payload, terminate word and IPG idles,
// back-to-back while en_i is high, stalling whenever ready_i is low.
//
// Ports:
//   clk, reset        - TX parallel clock, synchronous active-high reset
//   ready_i           - downstream accepts the current word on a rising edge
//   en_i              - generate frames while high
//   len_i             - frame length in bytes (min 8), sampled on entry to START
//   err_inj_i         - flag the next payload word as an error word
//   ctrl_v_o .. err_v_o, start_v_o, data_o, keep_o - registered pcs_tx input bus
//   frame_cnt_o       - completed frame count, bumps on the accepted terminate word
module pcs_tx_frame_gen #(
    parameter int unsigned IS_10G  = 1,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned IPG_CYC = 2,
    localparam int unsigned LANE0_CNT_N = (IS_10G != 0) ? 2 : 1,
    localparam int unsigned KEEP_W      = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ready_i,
    input  logic                   en_i,
    input  logic [15:0]            len_i,
    input  logic                   err_inj_i,
    output logic                   ctrl_v_o,
    output logic                   idle_v_o,
    output logic [LANE0_CNT_N-1:0] start_v_o,
    output logic                   term_v_o,
    output logic                   err_v_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [KEEP_W-1:0]      keep_o,
    output logic [31:0]            frame_cnt_o
);

    localparam int unsigned LEN_W = 16;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned IPG_W = 4;
    localparam int unsigned PAT_W = 8;

    localparam logic [LEN_W-1:0]  MIN_LEN    = LEN_W'(8);
    localparam logic [DATA_W-1:0] START_WORD = DATA_W'(64'hD555_5555_5555_5500);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_TERM,
        ST_IPG
    } state_e;

    // state_q names the word currently presented on the outputs
    state_e                 state_q, state_d;
    logic                   ctrl_v_q, ctrl_v_d;
    logic                   idle_v_q, idle_v_d;
    logic [LANE0_CNT_N-1:0] start_v_q, start_v_d;
    logic                   term_v_q, term_v_d;
    logic                   err_v_q, err_v_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [KEEP_W-1:0]      keep_q, keep_d;
    logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [LEN_W-1:0]       rem_q, rem_d;       // payload bytes not yet emitted
    logic [PAT_W-1:0]       pat_q, pat_d;       // value of the next payload byte
    logic [IPG_W-1:0]       ipg_cnt_q, ipg_cnt_d;
    logic                   err_pend_q, err_pend_d;

    logic [DATA_W-1:0]      data_word;
    logic [DATA_W-1:0]      term_word;
    logic [KEEP_W-1:0]      term_keep;
    logic                   err_flag;
    logic                   load_frame;
    logic                   emit_data;

    // Candidate payload and terminate words from the running pattern byte
    always_comb begin
        data_word = '0;
        term_word = '0;
        term_keep = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            data_word[8*i +: 8] = pat_q + PAT_W'(i);
            if (LEN_W'(i) < rem_q) begin
                term_word[8*i +: 8] = pat_q + PAT_W'(i);
                term_keep[i]        = 1'b1;
            end
        end
    end

    // A pulse arriving on the same edge as a payload word still flags that word
    assign err_flag = err_pend_q | err_inj_i;

    // Next-state and next-word logic; nothing but err_pend moves while stalled
    always_comb begin
        state_d     = state_q;
        ctrl_v_d    = ctrl_v_q;
        idle_v_d    = idle_v_q;
        start_v_d   = start_v_q;
        term_v_d    = term_v_q;
        err_v_d     = err_v_q;
        data_d      = data_q;
        keep_d      = keep_q;
        frame_cnt_d = frame_cnt_q;
        rem_d       = rem_q;
        pat_d       = pat_q;
        ipg_cnt_d   = ipg_cnt_q;
        err_pend_d  = err_flag;
        load_frame  = 1'b0;
        emit_data   = 1'b0;

        if (ready_i) begin
            ctrl_v_d  = 1'b1;
            idle_v_d  = 1'b1;
            start_v_d = '0;
            term_v_d  = 1'b0;
            err_v_d   = 1'b0;
            data_d    = '0;
            keep_d    = '0;

            case (state_q)
                ST_IDLE: begin
                    if (en_i) begin
                        load_frame = 1'b1;
                    end
                end
                ST_START: begin
                    emit_data = 1'b1;
                end
                ST_DATA: begin
                    if (rem_q < LEN_W'(KEEP_W)) begin
                        state_d  = ST_TERM;
                        idle_v_d = 1'b0;
                        term_v_d = 1'b1;
                        data_d   = term_word;
                        keep_d   = term_keep;
                    end else begin
                        emit_data = 1'b1;
                    end
                end
                ST_TERM: begin
                    state_d     = ST_IPG;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    ipg_cnt_d   = IPG_W'(1);
                end
                ST_IPG: begin
                    if (ipg_cnt_q >= IPG_W'(IPG_CYC)) begin
                        if (en_i) begin
                            load_frame = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        ipg_cnt_d = ipg_cnt_q + IPG_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Start word; frame_cnt_q already includes the previous frame here
            if (load_frame) begin
                state_d   = ST_START;
                idle_v_d  = 1'b0;
                start_v_d = LANE0_CNT_N'(1);
                data_d    = START_WORD;
                rem_d     = (len_i < MIN_LEN) ? MIN_LEN : len_i;
                pat_d     = frame_cnt_q[PAT_W-1:0];
            end

            // Full payload word; an error word keeps its payload but raises ctrl
            if (emit_data) begin
                state_d    = ST_DATA;
                ctrl_v_d   = err_flag;
                err_v_d    = err_flag;
                idle_v_d   = 1'b0;
                data_d     = data_word;
                keep_d     = '1;
                rem_d      = rem_q - LEN_W'(KEEP_W);
                pat_d      = pat_q + PAT_W'(KEEP_W);
                err_pend_d = 1'b0;
            end
        end
    end

    // State and output registers; reset wins over a stall
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ctrl_v_q    <= 1'b1;
            idle_v_q    <= 1'b1;
            start_v_q   <= '0;
            term_v_q    <= 1'b0;
            err_v_q     <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
            frame_cnt_q <= '0;
            rem_q       <= '0;
            pat_q       <= '0;
            ipg_cnt_q   <= '0;
            err_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_v_q    <= ctrl_v_d;
            idle_v_q    <= idle_v_d;
            start_v_q   <= start_v_d;
            term_v_q    <= term_v_d;
            err_v_q     <= err_v_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            frame_cnt_q <= frame_cnt_d;
            rem_q       <= rem_d;
            pat_q       <= pat_d;
            ipg_cnt_q   <= ipg_cnt_d;
            err_pend_q  <= err_pend_d;
        end
    end

    assign ctrl_v_o    = ctrl_v_q;
    assign idle_v_o    = idle_v_q;
    assign start_v_o   = start_v_q;
    assign term_v_o    = term_v_q;
    assign err_v_o     = err_v_q;
    assign data_o      = data_q;
    assign keep_o      = keep_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: doc/pcs_tx_frame_gen.md
# pcs_tx_frame_gen

Synthetic Ethernet frame source that drives the `pcs_tx` MAC-side input bus (ctrl/idle/start/term/err/keep/data), the same bus `pcs_rx` produces. It replaces the RX→TX loopback on the board top when the TX path must be brought up without a link partner. It emits start block, patterned payload, terminate block and inter-packet idles, and stalls on `pcs_tx` ready.

## Interface
- `IS_10G`, 1, selects lane-0 start width: `LANE0_CNT_N = IS_10G ? 2 : 1`.
- `DATA_W`, 64, data width; `KEEP_W = DATA_W/8` (derived, not overridable).
- `IPG_CYC`, 2, idle words emitted after every terminate word; legal range 1..15.
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: TX parallel clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ready_i` in 1: `pcs_tx` `ready_o`; 0 means the current output word is not consumed.
- `en_i` in 1: generate frames back-to-back while high.
- `len_i` in 16: frame length in bytes, preamble excluded; sampled on entry to START; values < 8 are treated as 8.
- `err_inj_i` in 1: flag the next emitted payload word as error.
- `ctrl_v_o`, `idle_v_o`, `term_v_o`, `err_v_o` out 1 each: to `pcs_tx` `*_v_i`.
- `start_v_o` out LANE0_CNT_N: bit 0 means start on lane 0; bit 1 is always 0.
- `data_o` out DATA_W: byte 0 = bits [7:0].
- `keep_o` out KEEP_W: valid bytes on the terminate word, low-justified.
- `frame_cnt_o` out 32: count of completed frames, incremented on the accepted terminate word; wraps.

## Operation
- States: IDLE, START, DATA, TERM, IPG. All outputs are registered. The state and every output advance only when `ready_i` = 1. When `ready_i` = 0, everything holds, including the internal counters.
- IDLE:
  - Outputs `ctrl_v`=1, `idle_v`=1, all other flags 0, `data`=0, `keep`=0.
  - If `en_i` = 1, go to START.
- START:
  - Outputs `ctrl_v`=1 and `start_v`=2'b01.
  - `data_o` = 64'hD555_5555_5555_5500 (byte 0 is ignored by the encoder).
  - Latches `L = max(len_i, 8)`, sets `rem = L` and `byte_idx = 0`, then goes to DATA.
- DATA:
  - Outputs `ctrl_v`=0, `keep`=FF.
  - Payload byte k of the frame = `(seq + k) mod 256`, where `seq = frame_cnt_o[7:0]` latched at START.
  - Each word decrements `rem` by 8.
  - Go to TERM when `rem` after the decrement is ≤ 7 (16-bit arithmetic, no underflow). Otherwise stay in DATA.
- TERM:
  - Outputs `ctrl_v`=1, `term_v`=1, `keep_o = (1<<rem)-1`.
  - Bytes [rem-1:0] carry the remaining payload; the upper bytes are 0.
  - When `L % 8 == 0`, the term word has `keep`=00 and `data`=0.
  - `frame_cnt_o` increments, then go to IPG.
- IPG:
  - Emits idle words, counting IPG_CYC accepted words.
  - On the last one, go to START if `en_i` = 1, else IDLE.
- Error injection:
  - `err_inj_i` sampled high in any state sets a sticky `err_pend`.
  - The next DATA word is emitted with `err_v_o`=1 and `ctrl_v_o`=1, with the payload unchanged.
  - `err_pend` clears when that word is accepted.
- `en_i` falling mid-frame: the current frame completes normally (TERM plus IPG), then go to IDLE.
- `reset`:
  - All outputs go to idle values (`ctrl_v`=1, `idle_v`=1, rest 0) on the next edge.
  - `frame_cnt_o` = 0, `err_pend` = 0, state = IDLE.
  - A frame in progress is dropped without a terminate word. This is intentional; `pcs_rx` on the far side flags it as an error.
- `reset` takes priority over `ready_i` = 0.

## Timing
- Latency:
  - `en_i` high in IDLE to the START word on outputs: 1 accepted cycle.
  - Frame of L bytes occupies 1 + floor(L/8) + 1 accepted words (start, data, term).
  - Minimum gap from term to the next start: exactly IPG_CYC words.
- Stall: while `ready_i` = 0, outputs are bit-identical cycle to cycle. A word counts as consumed on a rising edge with `ready_i` = 1.
- Reset values: `ctrl_v_o`=1, `idle_v_o`=1, `start_v_o`=0, `term_v_o`=0, `err_v_o`=0, `data_o`=0, `keep_o`=0, `frame_cnt_o`=0.
- `len_i` changes mid-frame have no effect until the next START.

## Test plan
- **Reset, then `en_i`=1, `len_i`=64, `ready_i`=1:** START word, then 8 DATA words with bytes 00..3F, then TERM with `keep`=00, then 2 idle words, then START. `frame_cnt_o` = 1 after the first TERM.
- **`len_i`=60:** START, 7 DATA words, TERM with `keep`=0F and data bytes 38,39,3A,3B.
- **`len_i`=3 (clamped to 8), then `ready_i` held 0 for 3 cycles during DATA:** exactly one DATA word and TERM `keep`=00. Outputs are frozen for all 3 stall cycles, and the frame length is unchanged.
- **`err_inj_i` pulse during START of a 64-byte frame:** first DATA word has `err_v_o`=1 and `ctrl_v_o`=1, payload 00..07. No other word in the frame is flagged.
- **`reset` asserted during the 4th DATA word:** next cycle shows idle outputs and `frame_cnt_o`=0. After release with `en_i`=1, a clean START appears 1 cycle later.
- **Continuous `en_i` with `ready_i` low 1 cycle in every 33:** 1000 frames complete, `frame_cnt_o`=1000, every gap is exactly 2 idle words, and the second frame's payload starts at byte 01.
